// File: rtl/store_merge_rmw.sv
// Store-size unit for the multicycle MIPS datapath. Accepts one store at a time.
// sw is written straight through. sb/sh read the aligned word, merge the new
// lanes, then write the word back. Alignment errors end the request early.
//
// Handshake: a request transfers in a cycle where req_valid and req_ready are
// both 1. req_ready is 1 only in IDLE. Request inputs are ignored otherwise.
// done (and err) pulse for one cycle when the request finishes.
module store_merge_rmw #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [1:0] SZ_W = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_B = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [15:0]        data_q, data_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               bad_q, bad_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [OFF_W-1:0]   req_off;
    logic               req_bad;
    logic [OFF_W-1:0]   off_next;
    logic [DATA_W-1:0]  merged;

    // Classify the incoming request: lane offset and alignment error.
    always_comb begin
        req_off = req_addr[OFF_W-1:0];
        req_bad = 1'b0;
        case (req_size)
            SZ_W:    req_bad = (req_off != '0);
            SZ_H:    req_bad = req_off[0];
            SZ_B:    req_bad = 1'b0;
            default: req_bad = 1'b1;
        endcase
    end

    // Overlay the latched byte/half onto the word returned by memory.
    always_comb begin
        merged   = mem_rdata;
        off_next = off_q + OFF_W'(1);
        for (int k = 0; k < NB; k++) begin
            if (size_q == SZ_B && off_q == OFF_W'(k)) begin
                merged[8*((BIG_ENDIAN != 0) ? NB-1-k : k) +: 8] = data_q[7:0];
            end
            if (size_q == SZ_H && off_q == OFF_W'(k)) begin
                merged[8*((BIG_ENDIAN != 0) ? NB-1-k : k) +: 8] =
                    (BIG_ENDIAN != 0) ? data_q[15:8] : data_q[7:0];
            end
            if (size_q == SZ_H && off_next == OFF_W'(k)) begin
                merged[8*((BIG_ENDIAN != 0) ? NB-1-k : k) +: 8] =
                    (BIG_ENDIAN != 0) ? data_q[7:0] : data_q[15:8];
            end
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        data_d  = data_q;
        word_d  = word_q;
        addr_d  = addr_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ready_q && req_valid) begin
                    size_d = req_size;
                    off_d  = req_off;
                    data_d = req_data[15:0];
                    word_d = req_data;
                    addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    bad_d  = req_bad;
                    if (req_bad)               state_d = S_DONE;
                    else if (req_size == SZ_W) state_d = S_WRITE;
                    else                       state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    word_d  = merged;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d  = (state_d == S_IDLE);
        mem_rd_d = (state_d == S_READ);
        mem_wr_d = (state_d == S_WRITE);
        wdata_d  = mem_wr_d ? word_d : '0;
        done_d   = (state_d == S_DONE);
        err_d    = done_d && bad_d;
    end

    // State and output registers; reset aborts any request without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            size_q   <= '0;
            off_q    <= '0;
            data_q   <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            off_q    <= off_d;
            data_q   <= data_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_addr  = addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: instance 0 is big-endian with MEM_LAT=1,
// instance 1 is little-endian with MEM_LAT=3. A small memory model returns the
// stored word exactly MEM_LAT cycles after mem_rd and its inverse otherwise.
module tb_store_merge_rmw;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        valid_a [2];
    logic        ready_a [2];
    logic        mem_rd_a [2];
    logic        mem_wr_a [2];
    logic        done_a [2];
    logic        err_a [2];
    logic [31:0] maddr_a [2];
    logic [31:0] wdata_a [2];
    logic [31:0] rdata_a [2];
    logic [31:0] word_a [2];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    logic [3:0] rp0 = '0;
    logic [3:0] rp1 = '0;

    store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .reset(reset), .req_valid(valid_a[0]), .req_ready(ready_a[0]),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .mem_addr(maddr_a[0]), .mem_rd(mem_rd_a[0]), .mem_wr(mem_wr_a[0]),
        .mem_wdata(wdata_a[0]), .mem_rdata(rdata_a[0]), .done(done_a[0]), .err(err_a[0])
    );

    store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .reset(reset), .req_valid(valid_a[1]), .req_ready(ready_a[1]),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .mem_addr(maddr_a[1]), .mem_rd(mem_rd_a[1]), .mem_wr(mem_wr_a[1]),
        .mem_wdata(wdata_a[1]), .mem_rdata(rdata_a[1]), .done(done_a[1]), .err(err_a[1])
    );

    // Memory read pipelines, one per instance.
    always @(posedge clk) begin
        rp0 <= {rp0[2:0], mem_rd_a[0]};
        rp1 <= {rp1[2:0], mem_rd_a[1]};
    end
    assign rdata_a[0] = rp0[0] ? word_a[0] : ~word_a[0];
    assign rdata_a[1] = rp1[2] ? word_a[1] : ~word_a[1];

    // Reference merge, written per byte position of the memory word.
    function automatic logic [31:0] model(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] size, input int off, input bit be);
        logic [31:0] r;
        logic [7:0]  src;
        int n;
        int p;
        r = w;
        if (size == 2'b01) return d;
        n = (size == 2'b11) ? 1 : 2;
        for (int i = 0; i < n; i++) begin
            p   = off + i;
            src = be ? d[8*(n-1-i) +: 8] : d[8*i +: 8];
            if (be) r[8*(3-p) +: 8] = src;
            else    r[8*p +: 8] = src;
        end
        return r;
    endfunction

    // Driver: presents one request in the current cycle (T) and records what the
    // chosen instance does until done, plus req_ready one cycle after done.
    task automatic run_txn(input int inst, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data,
                           output int t_rd, output int t_wr, output int t_done,
                           output int n_rd, output int n_wr, output logic err_seen,
                           output logic [31:0] wd_seen, output logic [31:0] ad_seen,
                           output logic rdy_start, output logic rdy_after, output int leaks);
        bit fin;
        t_rd = -1; t_wr = -1; t_done = -1; n_rd = 0; n_wr = 0;
        err_seen = 1'b0; wd_seen = '0; ad_seen = '0; rdy_after = 1'b0; leaks = 0; fin = 0;
        rdy_start = ready_a[inst];
        req_size = size; req_addr = addr; req_data = data;
        valid_a[inst] = 1'b1;
        @(posedge clk); #1;
        valid_a[inst] = 1'b0;
        req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_data = $urandom;
        for (int k = 1; k <= 20 && !fin; k++) begin
            if (mem_rd_a[inst]) begin
                n_rd++; t_rd = k;
                if (n_wr == 0) ad_seen = maddr_a[inst];
            end
            if (mem_wr_a[inst]) begin
                n_wr++; t_wr = k; wd_seen = wdata_a[inst];
                if (n_rd == 0) ad_seen = maddr_a[inst];
            end
            if (!mem_wr_a[inst] && wdata_a[inst] != 32'h0) leaks++;
            if (!done_a[inst] && err_a[inst]) leaks++;
            if (done_a[inst]) begin
                t_done = k; err_seen = err_a[inst]; fin = 1;
            end
            @(posedge clk); #1;
            if (fin) rdy_after = ready_a[inst];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({ready_a[i], mem_rd_a[i], mem_wr_a[i], done_a[i], err_a[i]} !== 5'b0 ||
                maddr_a[i] !== 32'h0 || wdata_a[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_outputs inst%0d: got rdy/rd/wr/done/err=%b%b%b%b%b addr=%h wdata=%h want all 0",
                         i, ready_a[i], mem_rd_a[i], mem_wr_a[i], done_a[i], err_a[i], maddr_a[i], wdata_a[i]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (ready_a[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready inst%0d: got %b want 1", i, ready_a[i]);
            end
        end
    endtask

    task automatic test_sw();
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad, exp;
        word_a[0] = 32'h0F0F0F0F;
        exp_q.push_back(32'hDEADBEEF);
        run_txn(0, 2'b01, 32'h100, 32'hDEADBEEF, t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
        vectors++;
        if (n_rd !== 0 || n_wr !== 1 || t_wr !== 1 || t_done !== 2 || e !== 1'b0 || leaks !== 0) begin
            miscompares++;
            $display("FAIL sw_timing: got n_rd=%0d n_wr=%0d t_wr=%0d t_done=%0d err=%b leaks=%0d want 0 1 1 2 0 0",
                     n_rd, n_wr, t_wr, t_done, e, leaks);
        end
        vectors++;
        if (ad !== 32'h100) begin
            miscompares++;
            $display("FAIL sw_addr: got %h want 00000100", ad);
        end
        exp = exp_q.pop_front();
        vectors++;
        if (wd !== exp) begin
            miscompares++;
            $display("FAIL sw_wdata: got %h want %h", wd, exp);
        end
    endtask

    task automatic test_subword();
        logic [1:0]  sz [4] = '{2'b11, 2'b11, 2'b10, 2'b10};
        logic [31:0] ad_t [4] = '{32'h203, 32'h201, 32'h202, 32'h200};
        logic [31:0] dt [4] = '{32'h000000AB, 32'h000000AB, 32'h0000CAFE, 32'h0000CAFE};
        logic [31:0] ex [4] = '{32'h112233AB, 32'h11AB3344, 32'h1122CAFE, 32'hCAFE3344};
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad, exp;
        word_a[0] = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            run_txn(0, sz[i], ad_t[i], dt[i], t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
            vectors++;
            if (n_rd !== 1 || t_rd !== 1 || n_wr !== 1 || t_wr !== 3 || t_done !== 4 || e !== 1'b0 || leaks !== 0) begin
                miscompares++;
                $display("FAIL sub_timing[%0d]: got n_rd=%0d t_rd=%0d n_wr=%0d t_wr=%0d t_done=%0d err=%b leaks=%0d want 1 1 1 3 4 0 0",
                         i, n_rd, t_rd, n_wr, t_wr, t_done, e, leaks);
            end
            vectors++;
            if (ad !== (ad_t[i] & 32'hFFFFFFFC)) begin
                miscompares++;
                $display("FAIL sub_addr[%0d]: got %h want %h", i, ad, ad_t[i] & 32'hFFFFFFFC);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (wd !== exp) begin
                miscompares++;
                $display("FAIL sub_wdata[%0d]: got %h want %h", i, wd, exp);
            end
        end
    endtask

    task automatic test_align_err();
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b00};
        logic [31:0] ad_t [3] = '{32'h201, 32'h102, 32'h100};
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad;
        for (int i = 0; i < 3; i++) begin
            run_txn(0, sz[i], ad_t[i], $urandom, t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
            vectors++;
            if (n_rd !== 0 || n_wr !== 0 || t_done !== 1 || e !== 1'b1 || ra !== 1'b1 || leaks !== 0) begin
                miscompares++;
                $display("FAIL align_err[%0d]: got n_rd=%0d n_wr=%0d t_done=%0d err=%b rdy_after=%b leaks=%0d want 0 0 1 1 1 0",
                         i, n_rd, n_wr, t_done, e, ra, leaks);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad, exp;
        wr_seen = 0;
        word_a[0] = 32'h11223344;
        req_size = 2'b11; req_addr = 32'h203; req_data = 32'hAB;
        valid_a[0] = 1'b1;
        @(posedge clk); #1;
        valid_a[0] = 1'b0;
        if (mem_wr_a[0]) wr_seen++;
        @(posedge clk); #1;
        if (mem_wr_a[0]) wr_seen++;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (mem_wr_a[0]) wr_seen++;
            vectors++;
            if ({ready_a[0], mem_rd_a[0], mem_wr_a[0], done_a[0], err_a[0]} !== 5'b0 ||
                maddr_a[0] !== 32'h0 || wdata_a[0] !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_reset_outputs[%0d]: got rdy/rd/wr/done/err=%b%b%b%b%b addr=%h wdata=%h want all 0",
                         c, ready_a[0], mem_rd_a[0], mem_wr_a[0], done_a[0], err_a[0], maddr_a[0], wdata_a[0]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        if (mem_wr_a[0]) wr_seen++;
        vectors++;
        if (ready_a[0] !== 1'b1 || mem_wr_a[0] !== 1'b0 || done_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_release: got rdy=%b wr=%b done=%b want 1 0 0", ready_a[0], mem_wr_a[0], done_a[0]);
        end
        vectors++;
        if (wr_seen !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_nowrite: got %0d writes want 0", wr_seen);
        end
        exp_q.push_back(32'h12345678);
        run_txn(0, 2'b01, 32'h104, 32'h12345678, t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
        exp = exp_q.pop_front();
        vectors++;
        if (n_wr !== 1 || t_wr !== 1 || t_done !== 2 || e !== 1'b0 || wd !== exp || ad !== 32'h104) begin
            miscompares++;
            $display("FAIL post_reset_sw: got n_wr=%0d t_wr=%0d t_done=%0d err=%b wdata=%h addr=%h want 1 1 2 0 %h 00000104",
                     n_wr, t_wr, t_done, e, wd, ad, exp);
        end
    endtask

    task automatic test_lat3_le();
        logic [1:0]  sz [2] = '{2'b11, 2'b10};
        logic [31:0] ad_t [2] = '{32'h301, 32'h302};
        logic [31:0] dt [2] = '{32'h00000055, 32'h0000BEEF};
        logic [31:0] ex [2] = '{32'hAABB55DD, 32'hBEEFCCDD};
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad, exp;
        word_a[1] = 32'hAABBCCDD;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex[i]);
            run_txn(1, sz[i], ad_t[i], dt[i], t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
            vectors++;
            if (n_rd !== 1 || t_rd !== 1 || n_wr !== 1 || t_wr !== 5 || t_done !== 6 || e !== 1'b0 || ad !== 32'h300) begin
                miscompares++;
                $display("FAIL lat3_timing[%0d]: got n_rd=%0d t_rd=%0d n_wr=%0d t_wr=%0d t_done=%0d err=%b addr=%h want 1 1 1 5 6 0 00000300",
                         i, n_rd, t_rd, n_wr, t_wr, t_done, e, ad);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (wd !== exp) begin
                miscompares++;
                $display("FAIL lat3_wdata[%0d]: got %h want %h", i, wd, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t_rd, t_wr, t_done, n_rd, n_wr, leaks;
        logic e, rs, ra;
        logic [31:0] wd, ad, exp, addr, data;
        logic [1:0] size;
        int off;
        for (int i = 0; i < 12; i++) begin
            size = 2'($urandom_range(1, 3));
            off  = (size == 2'b01) ? 0 : (size == 2'b10) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            addr = ($urandom & 32'hFFFFFFFC) | 32'(off);
            data = $urandom;
            word_a[0] = $urandom;
            exp_q.push_back(model(word_a[0], data, size, off, 1'b1));
            run_txn(0, size, addr, data, t_rd, t_wr, t_done, n_rd, n_wr, e, wd, ad, rs, ra, leaks);
            vectors++;
            if (rs !== 1'b1 || ra !== 1'b1 || n_wr !== 1 || e !== 1'b0 || leaks !== 0 ||
                t_wr !== ((size == 2'b01) ? 1 : 3) || ad !== (addr & 32'hFFFFFFFC)) begin
                miscompares++;
                $display("FAIL b2b_ctrl[%0d]: got rdy=%b/%b n_wr=%0d t_wr=%0d err=%b leaks=%0d addr=%h size=%0d",
                         i, rs, ra, n_wr, t_wr, e, leaks, ad, size);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (wd !== exp) begin
                miscompares++;
                $display("FAIL b2b_wdata[%0d]: got %h want %h (size %0d addr %h)", i, wd, exp, size, addr);
            end
        end
    endtask

    initial begin
        valid_a[0] = 1'b0;
        valid_a[1] = 1'b0;
        word_a[0] = '0;
        word_a[1] = '0;
        test_reset();
        test_sw();
        test_subword();
        test_align_err();
        test_reset_mid();
        test_lat3_le();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
